// File: rtl/adc_sample_buffer.sv
// adc_sample_buffer: ping-pong buffer for ADC words with one-cycle pop readout.
// Banks seal when full or on done. Optional dropped-write counter: ADC_BUF_OVF_COUNT_EN.
// Ports: clk, rst (sync, active-high); adc_out_wr/adc_data_in write side; done flush;
//   rd_en pop -> rd_data/rd_valid/rd_last; bank_ready/bank_count/rd_bank status;
//   overflow sticky drop flag; ovf_count saturating drop count (0 when disabled).
module adc_sample_buffer #(
  parameter int DEPTH = 64,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     adc_out_wr,
  input  logic [DW-1:0]            adc_data_in,
  input  logic                     done,
  input  logic                     rd_en,
  output logic [DW-1:0]            rd_data,
  output logic                     rd_valid,
  output logic                     rd_last,
  output logic                     bank_ready,
  output logic [$clog2(DEPTH):0]   bank_count,
  output logic                     rd_bank,
  output logic                     overflow,
  output logic [15:0]              ovf_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [0:0] R_IDLE  = 1'b0;
  localparam logic [0:0] R_DRAIN = 1'b1;

  logic [DW-1:0]        mem_q [2*DEPTH];

  logic                 wr_bank_q, wr_bank_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [1:0]           sealed_q, sealed_d;
  logic [1:0][CW-1:0]   len_q, len_d;
  logic [0:0]           state_q, state_d;
  logic                 rd_bank_q, rd_bank_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [DW-1:0]        rd_data_q, rd_data_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 rd_last_q, rd_last_d;
  logic                 ovf_q, ovf_d;

  logic                 wr_ok;
  logic                 wr_drop;
  logic                 full;
  logic                 flush;
  logic                 seal;
  logic [CW-1:0]        wr_cnt;
  logic                 pop;
  logic                 pop_last;

  // Acceptance uses the registered seal flag, so a bank released
  // this cycle only becomes writable on the next one.
  assign wr_ok    = adc_out_wr & ~sealed_q[wr_bank_q];
  assign wr_drop  = adc_out_wr &  sealed_q[wr_bank_q];
  assign full     = wr_ok & (wr_ptr_q == AW'(DEPTH - 1));
  // Fill level including this cycle's write, so done seals it too.
  assign wr_cnt   = {1'b0, wr_ptr_q} + {{AW{1'b0}}, wr_ok};
  assign flush    = done & ~full & (wr_cnt != '0);
  assign seal     = full | flush;
  assign pop      = (state_q == R_DRAIN) & rd_en;
  assign pop_last = pop & (({1'b0, rd_ptr_q} + 1'b1) == len_q[rd_bank_q]);

  always_comb begin
    wr_bank_d = wr_bank_q ^ seal;
    wr_ptr_d  = wr_ptr_q;
    if (seal)
      wr_ptr_d = '0;
    else if (wr_ok)
      wr_ptr_d = wr_ptr_q + 1'b1;

    sealed_d = sealed_q;
    len_d    = len_q;
    if (pop_last)
      sealed_d[rd_bank_q] = 1'b0;
    if (seal) begin
      sealed_d[wr_bank_q] = 1'b1;
      len_d[wr_bank_q]    = wr_cnt;
    end

    state_d   = state_q;
    rd_bank_d = rd_bank_q;
    rd_ptr_d  = rd_ptr_q;
    case (state_q)
      R_IDLE: begin
        if (sealed_q[rd_bank_q]) begin
          rd_ptr_d = '0;
          state_d  = R_DRAIN;
        end
      end
      R_DRAIN: begin
        if (pop)
          rd_ptr_d = rd_ptr_q + 1'b1;
        if (pop_last) begin
          rd_bank_d = ~rd_bank_q;
          state_d   = R_IDLE;
        end
      end
      default: state_d = R_IDLE;
    endcase

    rd_valid_d = pop;
    rd_last_d  = pop_last;
    rd_data_d  = pop ? mem_q[{rd_bank_q, rd_ptr_q}] : rd_data_q;
    ovf_d      = ovf_q | wr_drop;
  end

  always_ff @(posedge clk) begin
    if (wr_ok)
      mem_q[{wr_bank_q, wr_ptr_q}] <= adc_data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank_q  <= 1'b0;
      wr_ptr_q   <= '0;
      sealed_q   <= '0;
      len_q      <= '0;
      state_q    <= R_IDLE;
      rd_bank_q  <= 1'b0;
      rd_ptr_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      wr_bank_q  <= wr_bank_d;
      wr_ptr_q   <= wr_ptr_d;
      sealed_q   <= sealed_d;
      len_q      <= len_d;
      state_q    <= state_d;
      rd_bank_q  <= rd_bank_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      ovf_q      <= ovf_d;
    end
  end

`ifdef ADC_BUF_OVF_COUNT_EN
  logic [15:0] ovfc_q, ovfc_d;

  always_comb begin
    ovfc_d = ovfc_q;
    if (wr_drop && (ovfc_q != 16'hFFFF))
      ovfc_d = ovfc_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      ovfc_q <= '0;
    else
      ovfc_q <= ovfc_d;
  end

  assign ovf_count = ovfc_q;
`else
  assign ovf_count = '0;
`endif

  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign rd_last    = rd_last_q;
  assign bank_ready = (state_q == R_DRAIN);
  assign bank_count = (state_q == R_DRAIN) ? len_q[rd_bank_q] : '0;
  assign rd_bank    = rd_bank_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_adc_sample_buffer.sv
// tb_adc_sample_buffer: directed and random stimulus for adc_sample_buffer
// against a queue-based model of sealed banks, plus literal spot checks.
module tb_adc_sample_buffer;

  localparam int DEPTH = 4;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          adc_out_wr;
  logic [DW-1:0] adc_data_in;
  logic          done;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_last;
  logic          bank_ready;
  logic [2:0]    bank_count;
  logic          rd_bank;
  logic          overflow;
  logic [15:0]   ovf_count;

  always #5 clk = ~clk;

  adc_sample_buffer #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .adc_out_wr (adc_out_wr),
    .adc_data_in(adc_data_in),
    .done       (done),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_last    (rd_last),
    .bank_ready (bank_ready),
    .bank_count (bank_count),
    .rd_bank    (rd_bank),
    .overflow   (overflow),
    .ovf_count  (ovf_count)
  );

  int passed = 0;
  int total  = 0;

  // Model: words of the bank being filled, the flat stream of sealed
  // words, and the length of every sealed bank in sealing order.
  logic [31:0] fill[$];
  logic [31:0] sw[$];
  int          slen[$];
  int          m_cnt;
  bit          in_drain;
  int          rem;
  int          cur_len;
  bit          m_rdbank;
  bit          m_ovf;
  int          m_ovfc;
  bit          e_valid;
  bit          e_last;
  logic [31:0] e_data;

  logic [31:0] got[$];
  bit          gotl[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic model_step(bit wr, logic [31:0] d, bit dn, bit re, bit r);
    int pre;
    bit rel;
    bit sl;
    if (r) begin
      fill.delete(); sw.delete(); slen.delete();
      m_cnt = 0; in_drain = 0; rem = 0; cur_len = 0;
      m_rdbank = 0; m_ovf = 0; m_ovfc = 0;
      e_valid = 0; e_last = 0; e_data = 0;
      return;
    end
    pre = m_cnt; rel = 0; sl = 0;
    e_valid = 0; e_last = 0;
    if (in_drain) begin
      if (re) begin
        e_valid = 1;
        e_data = sw.pop_front();
        rem--;
        if (rem == 0) begin
          e_last = 1; rel = 1; in_drain = 0;
          void'(slen.pop_front());
          m_rdbank = ~m_rdbank;
        end
      end
    end else if (pre > 0) begin
      in_drain = 1; rem = slen[0]; cur_len = slen[0];
    end
    // With two banks, the writer's bank is sealed exactly when
    // both banks were sealed at the start of the cycle.
    if (wr) begin
      if (pre < 2) fill.push_back(d);
      else begin
        m_ovf = 1;
        if (m_ovfc < 65535) m_ovfc++;
      end
    end
    if (fill.size() == DEPTH || (dn && fill.size() > 0)) begin
      foreach (fill[i]) sw.push_back(fill[i]);
      slen.push_back(fill.size());
      fill.delete();
      sl = 1;
    end
    m_cnt = pre + int'(sl) - int'(rel);
  endtask

  task automatic cyc(bit wr, logic [31:0] d, bit dn, bit re, bit r);
    logic [31:0] e_ovfc;
    rst = r; adc_out_wr = wr; adc_data_in = d; done = dn; rd_en = re;
    @(posedge clk);
    #1;
    model_step(wr, d, dn, re, r);
`ifdef ADC_BUF_OVF_COUNT_EN
    e_ovfc = 32'(m_ovfc);
`else
    e_ovfc = 0;
`endif
    chk("rd_valid",   32'(rd_valid),   32'(e_valid));
    chk("rd_last",    32'(rd_last),    32'(e_last));
    chk("rd_data",    rd_data,         e_data);
    chk("bank_ready", 32'(bank_ready), 32'(in_drain));
    chk("bank_count", 32'(bank_count), in_drain ? 32'(cur_len) : 32'd0);
    chk("rd_bank",    32'(rd_bank),    32'(m_rdbank));
    chk("overflow",   32'(overflow),   32'(m_ovf));
    chk("ovf_count",  32'(ovf_count),  e_ovfc);
    if (rd_valid === 1'b1) begin
      got.push_back(rd_data);
      gotl.push_back(rd_last);
    end
  endtask

  task automatic wr_word(logic [31:0] d); cyc(1, d, 0, 0, 0); endtask
  task automatic idle();                  cyc(0, 0, 0, 0, 0); endtask
  task automatic pop();                   cyc(0, 0, 0, 1, 0); endtask
  task automatic do_reset();
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
  endtask

  initial begin
    rst = 1; adc_out_wr = 0; adc_data_in = 0; done = 0; rd_en = 0;

    do_reset();
    chk("reset_bank_ready", 32'(bank_ready), 0);
    chk("reset_rd_data", rd_data, 0);

    // Single bank fill
    for (int i = 0; i < 4; i++) wr_word(32'hA0 + i);
    idle();
    chk("fill_ready", 32'(bank_ready), 1);
    chk("fill_count", 32'(bank_count), 4);
    got.delete(); gotl.delete();
    for (int i = 0; i < 4; i++) pop();
    chk("fill_nwords", got.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("fill_word", got[i], 32'hA0 + i);
      chk("fill_last", 32'(gotl[i]), 32'(i == 3));
    end
    chk("fill_ready_after", 32'(bank_ready), 0);
    chk("fill_rd_bank", 32'(rd_bank), 1);

    // Ping-pong overflow
    do_reset();
    for (int i = 0; i < 9; i++) wr_word(32'h10 + i);
    chk("ovf_flag", 32'(overflow), 1);
`ifdef ADC_BUF_OVF_COUNT_EN
    chk("ovf_cnt", 32'(ovf_count), 1);
`else
    chk("ovf_cnt", 32'(ovf_count), 0);
`endif
    got.delete(); gotl.delete();
    for (int i = 0; i < 12; i++) pop();
    chk("ovf_nwords", got.size(), 8);
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      chk("ovf_word", got[i], 32'h10 + i);
      chk("ovf_last", 32'(gotl[i]), 32'(i == 3 || i == 7));
    end

    // Flush
    do_reset();
    for (int i = 1; i <= 3; i++) wr_word(i);
    cyc(0, 0, 1, 0, 0);
    idle();
    chk("flush_count", 32'(bank_count), 3);
    got.delete(); gotl.delete();
    for (int i = 0; i < 3; i++) pop();
    chk("flush_nwords", got.size(), 3);
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      chk("flush_word", got[i], i + 1);
      chk("flush_last", 32'(gotl[i]), 32'(i == 2));
    end
    wr_word(32'h55);
    cyc(0, 0, 1, 0, 0);
    idle();
    chk("flush_next_ready", 32'(bank_ready), 1);
    chk("flush_next_bank", 32'(rd_bank), 1);
    chk("flush_next_count", 32'(bank_count), 1);
    got.delete(); gotl.delete();
    pop();
    chk("flush_next_word", got.size() > 0 ? got[0] : 32'hDEAD, 32'h55);

    // Empty flush and idle pops
    do_reset();
    cyc(0, 0, 1, 0, 0);
    idle(); idle();
    chk("empty_flush_ready", 32'(bank_ready), 0);
    got.delete(); gotl.delete();
    for (int i = 0; i < 3; i++) pop();
    chk("idle_pop_none", got.size(), 0);
    for (int i = 0; i < 4; i++) wr_word(32'hC0 + i);
    idle();
    for (int i = 0; i < 4; i++) pop();
    chk("idle_pop_nwords", got.size(), 4);
    chk("idle_pop_first", got.size() > 0 ? got[0] : 32'hDEAD, 32'hC0);

    // Release race
    do_reset();
    for (int i = 0; i < 8; i++) wr_word(32'h20 + i);
    idle();
    for (int i = 0; i < 3; i++) pop();
    cyc(1, 32'h77, 0, 1, 0);
    chk("race_ovf", 32'(overflow), 1);
    for (int i = 0; i < 4; i++) wr_word(32'h78 + i);
    got.delete(); gotl.delete();
    for (int i = 0; i < 12; i++) pop();
    chk("race_nwords", got.size(), 8);
    chk("race_b1_first", got.size() > 0 ? got[0] : 32'hDEAD, 32'h24);
    chk("race_b0_first", got.size() > 4 ? got[4] : 32'hDEAD, 32'h78);

    // Reset mid-drain
    do_reset();
    for (int i = 0; i < 4; i++) wr_word(32'h30 + i);
    idle();
    pop(); pop();
    cyc(0, 0, 0, 0, 1);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_rd_last", 32'(rd_last), 0);
    chk("rst_ready", 32'(bank_ready), 0);
    chk("rst_count", 32'(bank_count), 0);
    chk("rst_rd_bank", 32'(rd_bank), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_ovf_count", 32'(ovf_count), 0);
    for (int i = 0; i < 4; i++) wr_word(32'h40 + i);
    idle();
    got.delete(); gotl.delete();
    for (int i = 0; i < 4; i++) pop();
    chk("rst_refill_nwords", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++)
      chk("rst_refill_word", got[i], 32'h40 + i);
    chk("rst_refill_bank", 32'(rd_bank), 1);

    // Randomized traffic with varying read pressure
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      int thr;
      bit r;
      bit w;
      bit dn;
      bit re;
      thr = (i / 250) % 10;
      r  = ($urandom_range(0, 999) == 0);
      w  = ($urandom_range(0, 1) == 1);
      dn = ($urandom_range(0, 19) == 0);
      re = ($urandom_range(0, 9) < thr);
      cyc(w, $urandom, dn, re, r);
    end

    rst = 0; adc_out_wr = 0; done = 0; rd_en = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/adc_sample_buffer.md
# adc_sample_buffer

Ping-pong sample buffer on the consumer side of the ADC control block's write interface. It captures each `adc_out_wr`-qualified 32-bit ADC word into one of two DEPTH-word banks. When a bank fills or an acquisition-complete pulse arrives, it seals that bank and presents it to a downstream reader (SPI/host readout) through a pop handshake with one-cycle latency. It sits between the ADC control FSM and the host readout logic and decouples acquisition rate from readout rate.

## Interface
- `DEPTH`, 64: words per bank; power of two, ≥ 2.
- `DW`, 32: data width; matches the ADC data word.
- `clk` in 1: system clock; all logic is on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `adc_out_wr` in 1: write strobe; one word per high cycle.
- `adc_data_in` in DW: sample data, qualified by `adc_out_wr`.
- `done` in 1: acquisition-complete pulse; flushes a partially filled bank.
- `rd_en` in 1: reader pop request.
- `rd_data` out DW: registered read data.
- `rd_valid` out 1: `rd_data` is valid this cycle; single-cycle pulse per pop.
- `rd_last` out 1: high together with `rd_valid` on the final word of a bank.
- `bank_ready` out 1: the bank at the read side is sealed and not yet drained.
- `bank_count` out $clog2(DEPTH)+1: word count of the sealed read bank; 0 when `bank_ready`=0.
- `rd_bank` out 1: index of the bank being read.
- `overflow` out 1: sticky; set when a write is dropped.
- `ovf_count` out 16: dropped-write counter (see Configuration).

## Operation
- **Storage:** two banks, `mem[2][DEPTH]`. Memory contents are not reset.
- **Writer state:** `wr_bank`, `wr_ptr`, `sealed[1:0]`, `len[1:0]`.
- **Write acceptance:** a write is accepted only if the registered `sealed[wr_bank]`=0. An accepted write stores to `mem[wr_bank][wr_ptr]` and increments `wr_ptr`.
- **Full seal:** an accepted write with `wr_ptr`=DEPTH-1 sets `sealed[wr_bank]`, sets `len[wr_bank]`=DEPTH, toggles `wr_bank`, and clears `wr_ptr`.
- **Dropped write:** a write to a sealed bank is discarded; `wr_ptr` is unchanged, `overflow` is set, and `ovf_count` increments (saturating at 0xFFFF).
- **Flush:** `done` with `wr_ptr`>0 seals the current bank with `len`=`wr_ptr`, then toggles `wr_bank` and clears `wr_ptr`. `done` with `wr_ptr`=0 is a no-op.
- **Write and `done` in the same cycle:** the write is applied first and `len` includes it. If that write fills the bank, a normal full seal occurs and `done` is consumed as a no-op.
- **Reader FSM:**
  - R_IDLE: if `sealed[rd_bank]`, clear `rd_ptr` and go to R_DRAIN.
  - R_DRAIN: `bank_ready`=1 and `bank_count`=`len[rd_bank]`. Each `rd_en` reads `mem[rd_bank][rd_ptr]` and increments `rd_ptr`.
  - On the pop where `rd_ptr`=`len`-1: assert `rd_last` with that word, clear `sealed[rd_bank]`, toggle `rd_bank`, return to R_IDLE.
- **`rd_en` outside R_DRAIN** is ignored: no `rd_valid` and no state change.
- **Release vs. write race:** a bank released in cycle N is not writable until cycle N+1. A write to it in cycle N is dropped and counted as overflow.
- **Ordering:** banks drain in sealing order, 0,1,0,1,…; words drain in write order.

## Timing
- **Reset values:** `rd_data`=0, `rd_valid`=0, `rd_last`=0, `bank_ready`=0, `bank_count`=0, `rd_bank`=0, `overflow`=0, `ovf_count`=0.
- **Internal reset state:** `wr_bank`=0, `wr_ptr`=0, `sealed`=00, reader FSM in R_IDLE.
- **Seal to ready:** a bank sealed at edge N (full seal or flush) is in R_DRAIN with `bank_ready`=1 after edge N+1.
- **Read latency:** `rd_en` sampled at edge N gives `rd_valid`/`rd_data` high after edge N+1. Back-to-back `rd_en` gives one word per cycle.
- **Last pop:** `bank_ready` falls at the same edge that produces the `rd_last` word.
- **Reset mid-operation:** all buffered data is discarded. The next cycle is identical to post-reset state.

## Configuration
- `ADC_BUF_OVF_COUNT_EN`
  - Defined: `ovf_count` is a 16-bit saturating counter of dropped writes, cleared only by `rst`.
  - Undefined: no counter logic is built and `ovf_count` is tied to 0. Sticky `overflow` is unaffected.

## Test plan
- **Single bank fill (DEPTH=4):** write 0xA0..0xA3 → `bank_ready`=1, `bank_count`=4; four `rd_en` → `rd_data` A0..A3, `rd_last` only on A3, then `bank_ready`=0 and `rd_bank`=1.
- **Ping-pong overflow (DEPTH=4, no reads):** write 0x10..0x18 → ninth write (0x18) dropped, `overflow`=1, `ovf_count`=1 (0 without macro); drain yields 0x10..0x17 in order with `rd_last` on 0x13 and 0x17.
- **Flush:** write 0x01,0x02,0x03 then `done` → `bank_count`=3; drain 3 words, `rd_last` on 0x03; the next write lands in bank 1.
- **Empty flush / idle pop:** `done` with `wr_ptr`=0 → `bank_ready` stays 0; `rd_en` pulses while `bank_ready`=0 → `rd_valid` never asserts, and a later fill reads from word 0.
- **Release race:** both banks sealed, a write in the cycle bank 0 is released → write dropped and `overflow` set; a write one cycle later is accepted at bank 0 word 0.
- **Reset mid-drain:** assert `rst` after 2 of 4 pops → all outputs 0 the next cycle; a fresh 4-word fill drains correctly from bank 0.
